sa_pass_scheduler: RTL

Sequencer that time-multiplexes one 4x4 systolic matrix-multiply array across the three fixed-point partial products of a self-attention matmul: INT×INT, INT×Frac, Frac×INT. For each job it selects operands, clears the array accumulators, waits for the array's completion strobe, and folds each pass result into a per-element combined sum. It then streams the 16 combined elements out, one per handshake. It sits between the attention datapath's operand buffers and the shared SystolicArray4x4 instance.

---
 rtl/sa_pkg.sv | 19 +
 rtl/sa_acc_bank.sv | 52 +++++
 rtl/sa_pass_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared encodings, state type and default widths for the systolic-array pass scheduler.
package sa_pkg;

  localparam int SA_WIDTH     = 8;
  localparam int SA_FRAC_BITS = 8;
  localparam int ACC_W        = 2*SA_WIDTH + SA_FRAC_BITS + 2;

  localparam logic [1:0] OP_II = 2'd0;
  localparam logic [1:0] OP_IF = 2'd1;
  localparam logic [1:0] OP_FI = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RUN,
    ST_STREAM
  } state_t;

endpackage

// File: rtl/sa_acc_bank.sv
// N*N signed accumulators with clear / load-shifted / add controls, updated in one cycle.
// The read port shows the post-update value, so a capture can feed the output register directly.
module sa_acc_bank
  import sa_pkg::*;
#(
  parameter int N         = 4,
  parameter int RW        = 16,
  parameter int FRAC_BITS = SA_FRAC_BITS,
  parameter int AW        = ACC_W,
  parameter int IW        = $clog2(N*N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load_shift,
  input  logic                add,
  input  logic [N*N*RW-1:0]   result,
  input  logic [IW-1:0]       rd_idx,
  output logic [AW-1:0]       rd_data
);

  logic signed [AW-1:0] acc_q [N*N];
  logic signed [AW-1:0] acc_d [N*N];
  logic signed [AW-1:0] ext   [N*N];

  for (genvar k = 0; k < N*N; k++) begin : g_ext
    assign ext[k] = {{(AW-RW){result[k*RW+RW-1]}}, result[k*RW +: RW]};
  end

  always_comb begin
    for (int k = 0; k < N*N; k++) begin
      acc_d[k] = acc_q[k];
      if (clr)
        acc_d[k] = '0;
      else if (load_shift)
        acc_d[k] = ext[k] <<< FRAC_BITS;
      else if (add)
        acc_d[k] = acc_q[k] + ext[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N*N; k++) acc_q[k] <= '0;
    end else begin
      for (int k = 0; k < N*N; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign rd_data = acc_d[rd_idx];

endmodule

// File: rtl/sa_pass_scheduler.sv
// Runs INT*INT, INT*Frac, Frac*INT passes on one shared array and streams the combined N*N results.
// Latency 1+3(1+D)+N*N cycles at full rate; the stream holds data/row/col stable while out_ready is low.
module sa_pass_scheduler
  import sa_pkg::*;
#(
  parameter int WIDTH     = SA_WIDTH,
  parameter int N         = 4,
  parameter int FRAC_BITS = SA_FRAC_BITS,
  parameter int TIMEOUT   = 64
) (
  input  logic                             clk,
  input  logic                             _reset,
  input  logic                             start_valid,
  output logic                             start_ready,
  output logic [1:0]                       op_sel,
  output logic                             sa_flush,
  input  logic                             sa_done,
  input  logic [N*N*2*WIDTH-1:0]           sa_result,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2*WIDTH+FRAC_BITS+1:0]     out_data,
  output logic [$clog2(N)-1:0]             out_row,
  output logic [$clog2(N)-1:0]             out_col,
  output logic                             busy,
  output logic                             err_timeout
);

  localparam int AW = 2*WIDTH + FRAC_BITS + 2;
  localparam int LN = $clog2(N);
  localparam int IW = 2*LN;
  localparam int CW = $clog2(TIMEOUT+1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N*N-1);
  localparam logic [CW-1:0] RUN_LIMIT = CW'(TIMEOUT-1);

  state_t          state;
  logic [1:0]      pass;
  logic [CW-1:0]   run_cnt;
  logic [IW-1:0]   idx;
  logic            run_done;
  logic            run_expire;
  logic            acc_clr;
  logic            acc_load;
  logic            acc_add;
  logic [IW-1:0]   rd_idx;
  logic [AW-1:0]   rd_data;

  assign run_done   = (state == ST_RUN) && sa_done;
  assign run_expire = (state == ST_RUN) && !sa_done && (run_cnt == RUN_LIMIT);
  assign acc_clr    = ((state == ST_IDLE) && start_valid) || run_expire;
  assign acc_load   = run_done && (pass == 2'd0);
  assign acc_add    = run_done && (pass != 2'd0);
  // Look ahead one element so out_data is already registered when the transfer completes.
  assign rd_idx     = (state == ST_STREAM) ? idx + IW'(1) : '0;

  assign out_row = idx[IW-1:LN];
  assign out_col = idx[LN-1:0];

  sa_acc_bank #(
    .N         (N),
    .RW        (2*WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .AW        (AW),
    .IW        (IW)
  ) u_acc_bank (
    .clk        (clk),
    .rst        (_reset),
    .clr        (acc_clr),
    .load_shift (acc_load),
    .add        (acc_add),
    .result     (sa_result),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  always_ff @(posedge clk or posedge _reset) begin
    if (_reset) begin
      state       <= ST_IDLE;
      pass        <= 2'd0;
      run_cnt     <= '0;
      idx         <= '0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      op_sel      <= OP_II;
      sa_flush    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      sa_flush    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            state       <= ST_FLUSH;
            pass        <= 2'd0;
            op_sel      <= OP_II;
            sa_flush    <= 1'b1;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ST_FLUSH: begin
          state   <= ST_RUN;
          run_cnt <= '0;
        end
        ST_RUN: begin
          // A done arriving on the last allowed cycle takes priority over the timeout.
          if (sa_done) begin
            if (pass == 2'd2) begin
              state     <= ST_STREAM;
              idx       <= '0;
              out_valid <= 1'b1;
              out_data  <= rd_data;
            end else begin
              state    <= ST_FLUSH;
              pass     <= pass + 2'd1;
              op_sel   <= (pass == 2'd0) ? OP_IF : OP_FI;
              sa_flush <= 1'b1;
            end
          end else if (run_cnt == RUN_LIMIT) begin
            state       <= ST_IDLE;
            err_timeout <= 1'b1;
            start_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            run_cnt <= run_cnt + CW'(1);
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state       <= ST_IDLE;
              out_valid   <= 1'b0;
              start_ready <= 1'b1;
              busy        <= 1'b0;
            end else begin
              idx      <= idx + IW'(1);
              out_data <= rd_data;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
